// File: rtl/pos_cell_reader.sv
// rtl/pos_cell_reader.sv - reads a particle cell (count word, then positions 1..count) into a 4-entry credited output FIFO
module pos_cell_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index
);

  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam int DEPTH = 4;

  typedef enum logic [2:0] {IDLE, CNT_RD, CNT_WAIT, STREAM, DRAIN, FIN} state_t;
  state_t state, next_state;

  logic                  wait_second;
  logic [ADDR_WIDTH-1:0] count_in;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic                  p1, p2;
  logic [ADDR_WIDTH-1:0] a1, a2;
  logic [DATA_WIDTH-1:0] fifo_data  [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_index [DEPTH];
  logic [2:0]            fifo_cnt, fifo_cnt_next;
  logic [1:0]            wr_pos;
  logic                  push, pop, credit_ok;
  logic                  busy_d, done_d, rden_d;
  logic [ADDR_WIDTH-1:0] addr_d;

  assign mem_wren  = 1'b0;
  assign count_in  = (mem_q[ADDR_WIDTH-1:0] > MAX_COUNT) ? MAX_COUNT : mem_q[ADDR_WIDTH-1:0];
  assign push      = p2;
  assign pop       = out_valid && out_ready;
  assign wr_pos    = fifo_cnt[1:0] - {1'b0, pop};
  assign fifo_cnt_next = fifo_cnt + {2'b0, push} - {2'b0, pop};
  // Credits are evaluated for the cycle the read would issue in: FIFO then, plus both pipeline stages then.
  assign credit_ok = ({1'b0, fifo_cnt_next} + {3'b0, mem_rden} + {3'b0, p1}) < 4'd4;
  assign out_data  = fifo_data[0];
  assign out_index = fifo_index[0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start) next_state = CNT_RD;
      CNT_RD:   next_state = CNT_WAIT;
      CNT_WAIT: if (wait_second) next_state = (count_in == '0) ? FIN : STREAM;
      STREAM:   if (mem_rden && mem_address == particle_count) next_state = DRAIN;
      DRAIN:    if (!p1 && fifo_cnt_next == 3'd0) next_state = FIN;
      FIN:      next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (next_state != IDLE) && (next_state != FIN);
    done_d = (next_state == FIN);
    rden_d = 1'b0;
    addr_d = mem_address;
    if (next_state == CNT_RD) begin
      rden_d = 1'b1;
      addr_d = '0;
    end else if (next_state == STREAM && credit_ok) begin
      rden_d = 1'b1;
      addr_d = issue_addr;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      mem_rden       <= 1'b0;
      mem_address    <= '0;
      particle_count <= '0;
      issue_addr     <= '0;
      wait_second    <= 1'b0;
      p1             <= 1'b0;
      p2             <= 1'b0;
      a1             <= '0;
      a2             <= '0;
    end else begin
      busy        <= busy_d;
      done        <= done_d;
      mem_rden    <= rden_d;
      mem_address <= addr_d;
      wait_second <= (state == CNT_WAIT) && !wait_second;
      if (state == CNT_WAIT && wait_second) particle_count <= count_in;
      if (state == IDLE)
        issue_addr <= ADDR_WIDTH'(1);
      else if (rden_d && next_state == STREAM)
        issue_addr <= issue_addr + 1'b1;
      // Only stream reads are tracked; the count word is consumed by the FSM.
      p1 <= mem_rden && (state == STREAM);
      a1 <= mem_address;
      p2 <= p1;
      a2 <= a1;
    end
  end

  // Shift-register FIFO: head is always entry 0, so the stream outputs are plain flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fifo_cnt  <= 3'd0;
      out_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i]  <= '0;
        fifo_index[i] <= '0;
      end
    end else begin
      fifo_cnt  <= fifo_cnt_next;
      out_valid <= (fifo_cnt_next != 3'd0);
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          fifo_data[i]  <= fifo_data[i+1];
          fifo_index[i] <= fifo_index[i+1];
        end
      end
      if (push) begin
        fifo_data[wr_pos]  <= mem_q;
        fifo_index[wr_pos] <= a2;
      end
    end
  end

endmodule

// File: tb/tb_pos_cell_reader.sv
// tb/tb_pos_cell_reader.sv - randomized bench for pos_cell_reader against a cell-memory reference model
module tb_pos_cell_reader;
  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b1;
  logic          busy, done, mem_rden, mem_wren, out_valid;
  logic [AW-1:0] particle_count, mem_address, out_index;
  logic [DW-1:0] mem_q, out_data;

  pos_cell_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .particle_count(particle_count), .mem_address(mem_address), .mem_rden(mem_rden),
    .mem_wren(mem_wren), .mem_q(mem_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  bit rnd_ready = 1'b0;
  int start_cyc = 0;

  // Cell memory model: word A appears on mem_q exactly two cycles after its read, junk otherwise.
  logic [DW-1:0] words [0:255];
  logic          r1 = 1'b0, r2 = 1'b0;
  logic [AW-1:0] a1 = '0, a2 = '0;
  logic [DW-1:0] junk = '0;
  int            cyc = 0;

  always @(posedge clock) begin
    cyc  <= cyc + 1;
    r1   <= mem_rden;
    a1   <= mem_address;
    r2   <= r1;
    a2   <= a1;
    junk <= {$urandom, $urandom, $urandom};
  end
  assign mem_q = r2 ? words[a2] : junk;

  // Observation records, written only here.
  int            got_idx[$];
  logic [DW-1:0] got_data[$];
  int            got_cyc[$];
  int            done_cyc[$];
  int            rd_cyc[$];
  int            in_flight = 0;
  int            stab_err = 0, occ_err = 0, busy_err = 0, wren_err = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [AW-1:0] prev_idx = '0;

  always @(negedge clock) begin
    if (!reset_n) begin
      in_flight  = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!out_valid || out_data !== prev_data || out_index !== prev_idx)) stab_err++;
      if (mem_rden && mem_address != '0) begin
        in_flight++;
        rd_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        got_idx.push_back(int'(out_index));
        got_data.push_back(out_data);
        got_cyc.push_back(cyc);
        in_flight--;
      end
      if (in_flight > 4) occ_err++;
      if (done) begin
        done_cyc.push_back(cyc);
        if (busy) busy_err++;
      end
      if (mem_wren) wren_err++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_index;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic load_cell(input int cnt);
    for (int i = 0; i < 256; i++) words[i] = {$urandom, $urandom, $urandom};
    words[0][AW-1:0] = cnt[AW-1:0];
  endtask

  task automatic run_readout(input int cnt, input int restart_at, input int budget, output bit timed_out);
    int nd;
    load_cell(cnt);
    nd = done_cyc.size();
    start = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
    for (int i = 1; i < budget && done_cyc.size() == nd; i++) begin
      if (i == restart_at) start = 1'b1;
      step();
      start = 1'b0;
    end
    timed_out = (done_cyc.size() == nd);
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({busy, done, out_valid, mem_rden} !== 4'b0 || mem_address !== '0 || particle_count !== '0 ||
        out_data !== '0 || out_index !== '0)
      $display("FAIL reset_state: busy=%b done=%b valid=%b rden=%b addr=%0d cnt=%0d idx=%0d data=%h required all 0",
               busy, done, out_valid, mem_rden, mem_address, particle_count, out_index, out_data);
    if ({busy, done, out_valid, mem_rden} !== 4'b0 || mem_address !== '0 || particle_count !== '0 ||
        out_data !== '0 || out_index !== '0) miscompares++;
    reset_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_count5();
    int b, nd, rb, n;
    bit to;
    b = got_idx.size(); nd = done_cyc.size(); rb = rd_cyc.size();
    rnd_ready = 1'b0;
    run_readout(5, -1, 200, to);
    n = got_idx.size() - b;
    vectors++;
    if (to) begin miscompares++; $display("FAIL c5_timeout: no done within budget"); end
    vectors++;
    if (n != 5) begin miscompares++; $display("FAIL c5_words: got %0d required 5", n); end
    for (int k = 0; k < n && k < 5; k++) begin
      vectors++;
      if (got_idx[b+k] != k + 1 || got_data[b+k] !== words[k+1]) begin
        miscompares++;
        $display("FAIL c5_word%0d: idx %0d data %h required idx %0d data %h", k, got_idx[b+k], got_data[b+k], k + 1, words[k+1]);
      end
      if (k > 0) begin
        vectors++;
        if (got_cyc[b+k] != got_cyc[b+k-1] + 1) begin
          miscompares++;
          $display("FAIL c5_consec%0d: cycle %0d required %0d", k, got_cyc[b+k], got_cyc[b+k-1] + 1);
        end
      end
    end
    if (n == 5 && done_cyc.size() > nd) begin
      vectors++;
      if (done_cyc[nd] != got_cyc[b+4] + 1) begin
        miscompares++;
        $display("FAIL c5_done_time: done at %0d required %0d", done_cyc[nd], got_cyc[b+4] + 1);
      end
    end
    if (n > 0 && rd_cyc.size() > rb) begin
      vectors++;
      if (got_cyc[b] - rd_cyc[rb] > 3) begin
        miscompares++;
        $display("FAIL c5_latency: first word %0d cycles after first read, required <= 3", got_cyc[b] - rd_cyc[rb]);
      end
    end
    vectors++;
    if (particle_count !== 8'd5) begin miscompares++; $display("FAIL c5_count: got %0d required 5", particle_count); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL c5_busy_after: got %b required 0", busy); end
  endtask

  task automatic test_count0();
    int b, nd, rb, be;
    bit to;
    b = got_idx.size(); nd = done_cyc.size(); rb = rd_cyc.size(); be = busy_err;
    rnd_ready = 1'b0;
    run_readout(0, -1, 50, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL c0_timeout: no done within budget"); end
    if (!to) begin
      vectors++;
      if (done_cyc[nd] - start_cyc != 4) begin
        miscompares++;
        $display("FAIL c0_done_time: done %0d cycles after start required 4", done_cyc[nd] - start_cyc);
      end
    end
    vectors++;
    if (got_idx.size() != b || rd_cyc.size() != rb) begin
      miscompares++;
      $display("FAIL c0_no_stream: words %0d reads %0d required 0 0", got_idx.size() - b, rd_cyc.size() - rb);
    end
    vectors++;
    if (busy_err != be) begin miscompares++; $display("FAIL c0_busy_with_done: busy high in %0d done cycles required 0", busy_err - be); end
    vectors++;
    if (particle_count !== 8'd0) begin miscompares++; $display("FAIL c0_count: got %0d required 0", particle_count); end
  endtask

  task automatic test_backpressure();
    int b, cnt, n, se, oe;
    bit to;
    rnd_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      cnt = (r == 0) ? 8 : int'($urandom_range(1, 40));
      b = got_idx.size(); se = stab_err; oe = occ_err;
      run_readout(cnt, -1, 3000, to);
      n = got_idx.size() - b;
      vectors++;
      if (to || n != cnt) begin
        miscompares++;
        $display("FAIL bp%0d_words: got %0d timeout %0d required %0d", r, n, to, cnt);
      end
      for (int k = 0; k < n && k < cnt; k++) begin
        vectors++;
        if (got_idx[b+k] != k + 1 || got_data[b+k] !== words[k+1]) begin
          miscompares++;
          $display("FAIL bp%0d_word%0d: idx %0d data %h required idx %0d data %h", r, k, got_idx[b+k], got_data[b+k], k + 1, words[k+1]);
        end
      end
      vectors++;
      if (stab_err != se) begin miscompares++; $display("FAIL bp%0d_stable: %0d unstable stalls required 0", r, stab_err - se); end
      vectors++;
      if (occ_err != oe) begin miscompares++; $display("FAIL bp%0d_credit: %0d over-credit cycles required 0", r, occ_err - oe); end
      vectors++;
      if (int'(particle_count) != cnt) begin miscompares++; $display("FAIL bp%0d_count: got %0d required %0d", r, particle_count, cnt); end
    end
    rnd_ready = 1'b0;
  endtask

  task automatic test_clamp();
    int b, n, exp_n;
    bit to;
    exp_n = PN - 1;
    b = got_idx.size();
    rnd_ready = 1'b0;
    run_readout(250, -1, 1000, to);
    n = got_idx.size() - b;
    vectors++;
    if (particle_count !== 8'(exp_n)) begin miscompares++; $display("FAIL clamp_count: got %0d required %0d", particle_count, exp_n); end
    vectors++;
    if (to || n != exp_n) begin miscompares++; $display("FAIL clamp_words: got %0d timeout %0d required %0d", n, to, exp_n); end
    for (int k = 0; k < n && k < exp_n; k++) begin
      vectors++;
      if (got_idx[b+k] != k + 1 || got_data[b+k] !== words[k+1]) begin
        miscompares++;
        $display("FAIL clamp_word%0d: idx %0d required %0d", k, got_idx[b+k], k + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int b, nd, n;
    bit to;
    rnd_ready = 1'b0;
    load_cell(10);
    b = got_idx.size();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 100 && got_idx.size() - b < 3; i++) step();
    vectors++;
    if (got_idx.size() - b != 3) begin miscompares++; $display("FAIL rm_pre_words: got %0d required 3", got_idx.size() - b); end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, out_valid, mem_rden} !== 4'b0 || mem_address !== '0 || particle_count !== '0 ||
        out_data !== '0 || out_index !== '0) begin
      miscompares++;
      $display("FAIL rm_reset_values: busy=%b done=%b valid=%b rden=%b addr=%0d cnt=%0d idx=%0d required all 0",
               busy, done, out_valid, mem_rden, mem_address, particle_count, out_index);
    end
    repeat (3) step();
    reset_n = 1'b1;
    nd = done_cyc.size();
    repeat (12) step();
    vectors++;
    if (done_cyc.size() != nd || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rm_no_done: done pulses %0d busy %b required 0 0", done_cyc.size() - nd, busy);
    end
    b = got_idx.size();
    run_readout(10, -1, 300, to);
    n = got_idx.size() - b;
    vectors++;
    if (to || n != 10) begin miscompares++; $display("FAIL rm_rerun_words: got %0d timeout %0d required 10", n, to); end
    for (int k = 0; k < n && k < 10; k++) begin
      vectors++;
      if (got_idx[b+k] != k + 1 || got_data[b+k] !== words[k+1]) begin
        miscompares++;
        $display("FAIL rm_rerun_word%0d: idx %0d required %0d", k, got_idx[b+k], k + 1);
      end
    end
  endtask

  task automatic test_start_busy();
    int b, nd;
    bit to;
    rnd_ready = 1'b0;
    b = got_idx.size(); nd = done_cyc.size();
    run_readout(6, 5, 300, to);
    repeat (20) step();
    vectors++;
    if (to || done_cyc.size() - nd != 1 || got_idx.size() - b != 6) begin
      miscompares++;
      $display("FAIL sb_stream: done pulses %0d words %0d required 1 6", done_cyc.size() - nd, got_idx.size() - b);
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL sb_busy: got %b required 0", busy); end
    b = got_idx.size(); nd = done_cyc.size();
    run_readout(0, 4, 50, to);
    repeat (20) step();
    vectors++;
    if (to || done_cyc.size() - nd != 1 || got_idx.size() != b || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_fin: done pulses %0d words %0d busy %b required 1 0 0", done_cyc.size() - nd, got_idx.size() - b, busy);
    end
    vectors++;
    if (wren_err != 0) begin miscompares++; $display("FAIL mem_wren: high in %0d cycles required 0", wren_err); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) words[i] = '0;
    test_reset();
    test_count5();
    test_count0();
    test_backpressure();
    test_clamp();
    test_reset_mid();
    test_start_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pos_cell_reader.md
POS_CELL_READER -- requirements
Module: pos_cell_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 96, giving the width of one position word {posz, posy, posx} of 3 x 32 bit.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, giving the cell memory address width.
REQ-003 The block SHALL have parameter PARTICLE_NUM, default 220, giving the cell memory depth; address 0 holds the particle count and addresses 1..PARTICLE_NUM-1 hold particles.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Port list (name, direction, width, meaning):
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a cell readout.
- busy  out  1  high from the start acceptance until done.
- done  out  1  one-cycle pulse when the readout is complete.
- particle_count  out  ADDR_WIDTH  count latched from address 0, after the clamp in REQ-009.
- mem_address  out  ADDR_WIDTH  cell memory address.
- mem_rden  out  1  cell memory read enable.
- mem_wren  out  1  cell memory write enable, constant 0.
- mem_q  in  DATA_WIDTH  cell memory read data.
- out_valid  out  1  out_data and out_index are valid.
- out_ready  in  1  consumer accepts the current word.
- out_data  out  DATA_WIDTH  position word.
- out_index  out  ADDR_WIDTH  particle address, 1..count.

Function
REQ-006 Memory timing SHALL be as follows: when mem_rden=1 with address A in cycle t, mem_q holds word A in cycle t+2 and in no other cycle.
REQ-007 The state machine SHALL have the states IDLE, CNT_RD, CNT_WAIT, STREAM, DRAIN and FIN.
REQ-008 IDLE SHALL behave as follows:
- start=1 moves the block to CNT_RD and sets busy=1.
- start is ignored in every state other than IDLE.
REQ-009 The count read SHALL proceed as follows:
- CNT_RD issues a read of address 0 for exactly one cycle.
- CNT_WAIT lasts 2 cycles, then latches count = mem_q[ADDR_WIDTH-1:0], clamped to PARTICLE_NUM-1.
- If count=0, the next state is FIN; otherwise it is STREAM.
REQ-010 STREAM SHALL issue reads at addresses 1,2,...,count, ascending, at most one per cycle.
- A read is issued only when (outstanding reads + FIFO occupancy) < 4.
- After the read of address count is issued, the next state is DRAIN.
REQ-011 Returning words SHALL enter a 4-entry output FIFO together with their address.
- The credit rule in REQ-010 guarantees the FIFO never overflows and no returning word is ever dropped.
REQ-012 The output handshake SHALL follow these rules:
- A word transfers in any cycle where out_valid=1 and out_ready=1.
- While out_ready=0, out_valid, out_data and out_index stay stable.
- Words are delivered in address order with no gaps or duplicates.
REQ-013 Throughput SHALL be 1 word per cycle while out_ready is held high, with the first out_valid no later than 3 cycles after the first STREAM read.
REQ-014 DRAIN SHALL wait until there are no outstanding reads and the FIFO is empty, then move to FIN.
REQ-015 FIN SHALL last one cycle, pulse done=1, clear busy, and return to IDLE.
- If start=1 is present in the FIN cycle, it is ignored.
REQ-016 mem_rden SHALL be 1 only in cycles that issue a read, and mem_address SHALL hold its last value otherwise.
REQ-017 All control outputs SHALL come directly from registers.

Reset
REQ-018 While reset_n=0, at any time, the block SHALL be in IDLE with busy=0, done=0, out_valid=0, mem_rden=0, mem_address=0, particle_count=0, out_data=0, out_index=0, the FIFO empty and the outstanding count at 0.
REQ-019 Reset asserted mid-readout SHALL abort the readout without a done pulse.
- Memory data still in flight is discarded after reset_n rises.
- The first start after reset performs a complete readout.

Verification
REQ-020 Count 5, out_ready=1 -> 5 words with out_index 1..5 on consecutive cycles, then done 1 cycle later, particle_count=5.
REQ-021 Count 0 -> no out_valid, done is asserted 4 cycles after start, and busy falls with done.
REQ-022 Count 8, out_ready toggled randomly at 50% -> all 8 words delivered in order, data stable while stalled, FIFO occupancy never exceeds 4, and reads are suppressed while credits are 0.
REQ-023 Count 250 with PARTICLE_NUM=220 -> particle_count=219 and 219 words are delivered.
REQ-024 reset_n pulled low during STREAM of count 10 after 3 words -> outputs go to their reset values immediately, no done pulse occurs, and a subsequent start reads all 10.
REQ-025 start pulsed while busy -> no effect: there is no second readout and exactly one done pulse.
